rf_dump_unit: RTL and testbench
===============================

RF_DUMP_UNIT -- requirements
Module: rf_dump_unit

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default `DATA_WIDTH (32), register data width.
REQ-002 The block SHALL have parameter REG_COUNT, default 32, number of architectural registers dumped.
REQ-003 The block SHALL have port clk  input  1  single clock; all state rises on posedge clk.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port dump_req_i  input  1  start request, sampled only in IDLE.
REQ-006 The block SHALL have port halt_o  output  1  freeze request to the pipeline (stall fetch, block RF writeback).
REQ-007 The block SHALL have port halted_i  input  1  pipeline acknowledges freeze.
REQ-008 The block SHALL have port rf_dbg_addr_o  output  5  debug read address into the register file.
REQ-009 The block SHALL have port rf_dbg_data_i  input  DATA_WIDTH  combinational RF read data for rf_dbg_addr_o.
REQ-010 The block SHALL have port out_valid_o  output  1  dump beat valid.
REQ-011 The block SHALL have port out_ready_i  input  1  sink ready; a beat transfers when valid and ready are both high on a clk edge.
REQ-012 The block SHALL have port out_idx_o  output  5  register index of the current beat.
REQ-013 The block SHALL have port out_data_o  output  DATA_WIDTH  register value of the current beat.
REQ-014 The block SHALL have port out_last_o  output  1  high on the beat with index REG_COUNT-1.
REQ-015 The block SHALL have port busy_o  output  1  high in every state except IDLE.
REQ-016 The block SHALL have port done_o  output  1  one-cycle pulse when a dump completes.
REQ-017 The block SHALL have port abort_o  output  1  one-cycle pulse when a dump is abandoned.

Function
REQ-018 The FSM SHALL have states IDLE, HALT_WAIT, READ, SEND, DONE.
REQ-019 IDLE -> HALT_WAIT when dump_req_i=1; the index counter is cleared to 0.
REQ-020 halt_o SHALL be 1 in HALT_WAIT, READ and SEND, and 0 in IDLE and DONE.
REQ-021 HALT_WAIT -> READ on the first cycle halted_i=1; there is no timeout.
REQ-022 In READ the block SHALL drive rf_dbg_addr_o=index, capture rf_dbg_data_i and index into the output register, then go to SEND.
REQ-023 In SEND out_valid_o SHALL be 1, and out_idx_o, out_data_o and out_last_o SHALL hold stable until the handshake.
REQ-024 On a SEND handshake with index<REG_COUNT-1: index increments by 1 and the FSM goes to READ. With index=REG_COUNT-1: the FSM goes to DONE.
REQ-025 Throughput SHALL be one beat per 2 cycles at most, and first beat valid SHALL come 2 cycles after halted_i is seen.
REQ-026 DONE SHALL last exactly one cycle with done_o=1, then go to IDLE.
REQ-027 If halted_i=0 in READ or SEND, the block SHALL go to IDLE and pulse abort_o. out_valid_o SHALL drop in that same cycle, with no further beats.
REQ-028 dump_req_i SHALL be ignored while busy_o=1, and a request held high in DONE SHALL start a new dump only after IDLE is re-entered.
REQ-029 The index counter SHALL be 5 bits and SHALL never exceed REG_COUNT-1 (no wrap).
REQ-030 rf_dbg_addr_o SHALL equal the index in all states.
REQ-031 Index 0 SHALL be dumped as returned by the RF, with no forced zero.

Reset
REQ-032 With rst_n=0 the FSM SHALL be IDLE, index 0, and all outputs 0 (halt_o, out_valid_o, out_idx_o, out_data_o, out_last_o, busy_o, done_o, abort_o, rf_dbg_addr_o), asynchronously.
REQ-033 Reset asserted mid-dump SHALL release halt_o immediately, and no done_o or abort_o SHALL be produced.
REQ-034 After rst_n deasserts, the first FSM transition SHALL occur at the next clk edge.

Structure
REQ-035 Package pipeline_debug_pkg SHALL hold the FSM state enum typedef and the constants RF_DUMP_REG_COUNT=32 and RF_ADDR_WIDTH=5.
REQ-036 The block SHALL be a single module with no sub-module, and the pipeline SHALL supply the RF debug read port.

Verification
REQ-037 Full dump: RF preloaded with x[i]=0x1000_0000+i, halted_i tied 1 after 1 cycle, out_ready_i=1 -> 32 beats with idx 0..31 and data 0x1000_0000..0x1000_001F, out_last_o only on idx 31, done_o one cycle later, halt_o low after done.
REQ-038 Backpressure: out_ready_i=0 for 5 cycles on beat idx 7 -> idx 7 and its data stable for those 5 cycles, no beat lost or duplicated.
REQ-039 Halt handshake: halted_i delayed 10 cycles -> halt_o=1 and out_valid_o=0 for those 10 cycles, first beat 2 cycles after halted_i rises.
REQ-040 Abort: halted_i dropped while in SEND on idx 12 -> abort_o pulses once, out_valid_o=0 and halt_o=0 next cycle, no done_o.
REQ-041 Reset mid-dump: rst_n low during beat idx 20 -> all outputs 0 immediately; a new dump_req_i afterwards restarts from idx 0.
REQ-042 Request while busy: dump_req_i pulsed at idx 3 -> ignored, exactly 32 beats and one done_o.

Source files
------------

// File: rtl/pipeline_debug_pkg.sv
// Shared definitions for the pipeline debug blocks: register-file dump FSM states and sizing.
package pipeline_debug_pkg;

  localparam int unsigned RF_DUMP_REG_COUNT = 32;
  localparam int unsigned RF_ADDR_WIDTH     = 5;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_HALT_WAIT = 3'd1,
    ST_READ      = 3'd2,
    ST_SEND      = 3'd3,
    ST_DONE      = 3'd4
  } rf_dump_state_e;

endpackage

// File: rtl/rf_dump_unit.sv
// Freezes the pipeline, then streams every architectural register out as
// (index, value) beats over a valid/ready interface.
module rf_dump_unit
  import pipeline_debug_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_COUNT  = RF_DUMP_REG_COUNT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     dump_req_i,
  output logic                     halt_o,
  input  logic                     halted_i,
  output logic [RF_ADDR_WIDTH-1:0] rf_dbg_addr_o,
  input  logic [DATA_WIDTH-1:0]    rf_dbg_data_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [RF_ADDR_WIDTH-1:0] out_idx_o,
  output logic [DATA_WIDTH-1:0]    out_data_o,
  output logic                     out_last_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     abort_o
);

  localparam int unsigned IDX_W = RF_ADDR_WIDTH;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REG_COUNT - 1);

  rf_dump_state_e         state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [IDX_W-1:0]       out_idx_q, out_idx_d;
  logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
  logic                   out_last_q, out_last_d;
  logic                   halt_q, halt_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   abort_q, abort_d;

  // Next-state and next-output logic; outputs are derived from the next state
  // so every output flop matches the state it is entering.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    out_idx_d  = out_idx_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    abort_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (dump_req_i) begin
          state_d = ST_HALT_WAIT;
          idx_d   = '0;
        end
      end
      ST_HALT_WAIT: begin
        if (halted_i) state_d = ST_READ;
      end
      ST_READ: begin
        if (!halted_i) begin
          state_d = ST_IDLE;
          abort_d = 1'b1;
        end else begin
          out_idx_d  = idx_q;
          out_data_d = rf_dbg_data_i;
          out_last_d = (idx_q == LAST_IDX);
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        // Losing the freeze wins over a same-cycle handshake.
        if (!halted_i) begin
          state_d = ST_IDLE;
          abort_d = 1'b1;
        end else if (out_ready_i) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_READ;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    halt_d  = (state_d == ST_HALT_WAIT) || (state_d == ST_READ) || (state_d == ST_SEND);
    valid_d = (state_d == ST_SEND);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      out_idx_q  <= '0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      halt_q     <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      out_idx_q  <= out_idx_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
      halt_q     <= halt_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      abort_q    <= abort_d;
    end
  end

  assign halt_o        = halt_q;
  assign rf_dbg_addr_o = idx_q;
  assign out_valid_o   = valid_q;
  assign out_idx_o     = out_idx_q;
  assign out_data_o    = out_data_q;
  assign out_last_o    = out_last_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign abort_o       = abort_q;

endmodule

// File: tb/tb_rf_dump_unit.sv
// Directed bench for rf_dump_unit: full dump, backpressure, delayed halt, abort,
// mid-dump reset and requests while busy.
module tb_rf_dump_unit;

  logic        clk;
  logic        rst_n;
  logic        dump_req_i;
  logic        halt_o;
  logic        halted_i;
  logic [4:0]  rf_dbg_addr_o;
  logic [31:0] rf_dbg_data_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [4:0]  out_idx_o;
  logic [31:0] out_data_o;
  logic        out_last_o;
  logic        busy_o;
  logic        done_o;
  logic        abort_o;

  logic [31:0] rf [32];
  int tests = 0;
  int fails = 0;

  rf_dump_unit #(.DATA_WIDTH(32), .REG_COUNT(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dump_req_i   (dump_req_i),
    .halt_o       (halt_o),
    .halted_i     (halted_i),
    .rf_dbg_addr_o(rf_dbg_addr_o),
    .rf_dbg_data_i(rf_dbg_data_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_idx_o    (out_idx_o),
    .out_data_o   (out_data_o),
    .out_last_o   (out_last_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .abort_o      (abort_o)
  );

  assign rf_dbg_data_i = rf[rf_dbg_addr_o];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_beat(input int idx, input string tag);
    int c = 0;
    while (!(out_valid_o && int'(out_idx_o) == idx) && c < 300) begin
      tick();
      c++;
    end
    chk(tag, 64'(out_valid_o && int'(out_idx_o) == idx), 64'(1));
  endtask

  // Drains one dump from the current point, checking every beat against rf[].
  // Optionally stalls beat bp_idx for 5 cycles and pulses dump_req_i on req_idx.
  task automatic run_dump(input int bp_idx, input int req_idx);
    int beats = 0;
    int cyc = 0;
    int bp_cnt = 0;
    int stray = 0;
    while (beats < 32 && cyc < 600) begin
      dump_req_i = 1'b0;
      if (out_valid_o) begin
        if (int'(out_idx_o) == bp_idx && bp_cnt < 5) begin
          out_ready_i = 1'b0;
          bp_cnt++;
          chk("bp_idx_stable", 64'(out_idx_o), 64'(bp_idx));
          chk("bp_data_stable", 64'(out_data_o), 64'(rf[bp_idx]));
        end else begin
          out_ready_i = 1'b1;
          chk("beat_idx", 64'(out_idx_o), 64'(beats));
          chk("beat_data", 64'(out_data_o), 64'(rf[beats]));
          chk("beat_last", 64'(out_last_o), 64'(beats == 31));
          chk("beat_rf_addr", 64'(rf_dbg_addr_o), 64'(beats));
          if (int'(out_idx_o) == req_idx) dump_req_i = 1'b1;
          beats++;
        end
      end
      if (done_o || abort_o) stray++;
      tick();
      cyc++;
    end
    dump_req_i  = 1'b0;
    out_ready_i = 1'b1;
    chk("beat_count", 64'(beats), 64'(32));
    chk("bp_cycles", 64'(bp_cnt), 64'((bp_idx >= 0) ? 5 : 0));
    chk("stray_pulse", 64'(stray), 64'(0));
    chk("done_pulse", 64'(done_o), 64'(1));
    chk("done_halt_low", 64'(halt_o), 64'(0));
    chk("done_valid_low", 64'(out_valid_o), 64'(0));
  endtask

  initial begin
    rst_n       = 1'b0;
    dump_req_i  = 1'b0;
    halted_i    = 1'b0;
    out_ready_i = 1'b1;
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + 32'(i);

    // Reset state
    #3;
    chk("rst_halt", 64'(halt_o), 64'(0));
    chk("rst_valid", 64'(out_valid_o), 64'(0));
    chk("rst_idx", 64'(out_idx_o), 64'(0));
    chk("rst_data", 64'(out_data_o), 64'(0));
    chk("rst_last", 64'(out_last_o), 64'(0));
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_done", 64'(done_o), 64'(0));
    chk("rst_abort", 64'(abort_o), 64'(0));
    chk("rst_addr", 64'(rf_dbg_addr_o), 64'(0));
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_busy", 64'(busy_o), 64'(0));

    // Full dump, halt acknowledged one cycle after the request
    dump_req_i = 1'b1;
    tick();
    chk("hw_halt", 64'(halt_o), 64'(1));
    chk("hw_busy", 64'(busy_o), 64'(1));
    chk("hw_valid", 64'(out_valid_o), 64'(0));
    dump_req_i = 1'b0;
    halted_i   = 1'b1;
    tick();
    chk("read_valid", 64'(out_valid_o), 64'(0));
    tick();
    chk("first_valid", 64'(out_valid_o), 64'(1));
    run_dump(-1, -1);

    // Request held into DONE only starts after IDLE is re-entered
    dump_req_i = 1'b1;
    halted_i   = 1'b0;
    tick();
    chk("post_done_idle", 64'(busy_o), 64'(0));
    chk("post_done_no_done", 64'(done_o), 64'(0));
    tick();
    chk("restart_busy", 64'(busy_o), 64'(1));
    chk("restart_halt", 64'(halt_o), 64'(1));
    dump_req_i = 1'b0;

    // Halt acknowledge delayed 10 cycles, then backpressure on beat 7
    for (int i = 0; i < 32; i++) rf[i] = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_A5A5;
    rf[0] = 32'hDEAD_BEEF;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hwait_halt", 64'(halt_o), 64'(1));
      chk("hwait_valid", 64'(out_valid_o), 64'(0));
    end
    halted_i = 1'b1;
    tick();
    chk("hwait_read_valid", 64'(out_valid_o), 64'(0));
    tick();
    chk("hwait_first_valid", 64'(out_valid_o), 64'(1));
    chk("hwait_first_idx", 64'(out_idx_o), 64'(0));
    run_dump(7, -1);
    tick();
    chk("idle_after_done", 64'(busy_o), 64'(0));

    // Abort on beat 12
    dump_req_i = 1'b1;
    tick();
    dump_req_i = 1'b0;
    wait_beat(12, "reach_beat12");
    halted_i = 1'b0;
    tick();
    chk("abort_pulse", 64'(abort_o), 64'(1));
    chk("abort_valid", 64'(out_valid_o), 64'(0));
    chk("abort_halt", 64'(halt_o), 64'(0));
    chk("abort_no_done", 64'(done_o), 64'(0));
    chk("abort_busy", 64'(busy_o), 64'(0));
    tick();
    chk("abort_once", 64'(abort_o), 64'(0));
    chk("abort_no_beat", 64'(out_valid_o), 64'(0));

    // Reset during beat 20, then restart with a request pulsed while busy
    halted_i   = 1'b1;
    dump_req_i = 1'b1;
    tick();
    dump_req_i = 1'b0;
    wait_beat(20, "reach_beat20");
    rst_n = 1'b0;
    #1;
    chk("mrst_halt", 64'(halt_o), 64'(0));
    chk("mrst_valid", 64'(out_valid_o), 64'(0));
    chk("mrst_idx", 64'(out_idx_o), 64'(0));
    chk("mrst_data", 64'(out_data_o), 64'(0));
    chk("mrst_busy", 64'(busy_o), 64'(0));
    chk("mrst_done", 64'(done_o), 64'(0));
    chk("mrst_abort", 64'(abort_o), 64'(0));
    chk("mrst_addr", 64'(rf_dbg_addr_o), 64'(0));
    tick();
    rst_n      = 1'b1;
    dump_req_i = 1'b1;
    tick();
    chk("post_rst_busy", 64'(busy_o), 64'(1));
    chk("post_rst_halt", 64'(halt_o), 64'(1));
    dump_req_i = 1'b0;
    run_dump(-1, 3);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("busy_req_ignored", 64'(busy_o), 64'(0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
